// File: rtl/life_cell_serial.sv
// Serial Game-of-Life cell: eight neighbour bits arrive over valid/ready, are counted
// with three_bit_adder, then the life rule updates state_q. Define LIFE_HIGHLIFE_EN for B36/S23.

module three_bit_adder (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] sum,
    output logic       carry
);
    logic [3:0] c;

    // Plain ripple-carry chain; carry-out becomes bit 3 of the consumer's count.
    always_comb begin
        c[0] = 1'b0;
        sum  = '0;
        for (int i = 0; i < 3; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        carry = c[3];
    end
endmodule

module life_cell_serial #(
    parameter logic INIT_STATE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       load_val,
    input  logic       start,
    input  logic       nb_valid,
    input  logic       nb_bit,
    output logic       nb_ready,
    output logic       state_q,
    output logic [3:0] count_q,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        APPLY = 2'd2
    } fsm_t;

    fsm_t       fsm;
    fsm_t       fsm_next;
    logic [2:0] idx;
    logic [2:0] idx_next;
    logic [3:0] count_next;
    logic       state_next;
    logic       done_next;
    logic [2:0] add_sum;
    logic       add_carry;

    three_bit_adder u_adder (
        .a     (count_q[2:0]),
        .b     ({2'b00, nb_bit}),
        .sum   (add_sum),
        .carry (add_carry)
    );

    function automatic logic life_rule(input logic alive, input logic [3:0] n);
`ifdef LIFE_HIGHLIFE_EN
        return (n == 4'd3) | (alive & (n == 4'd2)) | (~alive & (n == 4'd6));
`else
        return (n == 4'd3) | (alive & (n == 4'd2));
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            idx     <= '0;
            count_q <= '0;
            state_q <= INIT_STATE;
            done    <= 1'b0;
        end else begin
            fsm     <= fsm_next;
            idx     <= idx_next;
            count_q <= count_next;
            state_q <= state_next;
            done    <= done_next;
        end
    end

    // Count stays below 8 until the final bit, so bit 3 only ever comes from the adder carry.
    always_comb begin
        fsm_next   = fsm;
        idx_next   = idx;
        count_next = count_q;
        state_next = state_q;
        done_next  = 1'b0;
        case (fsm)
            IDLE: begin
                if (load) begin
                    state_next = load_val;
                end else if (start) begin
                    count_next = '0;
                    idx_next   = '0;
                    fsm_next   = ACCUM;
                end
            end
            ACCUM: begin
                if (nb_valid) begin
                    count_next = {add_carry, add_sum};
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        fsm_next = APPLY;
                    end
                end
            end
            APPLY: begin
                state_next = life_rule(state_q, count_q);
                done_next  = 1'b1;
                fsm_next   = IDLE;
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    assign nb_ready = (fsm == ACCUM);
    assign busy     = (fsm != IDLE);
endmodule

// File: tb/tb_life_cell_serial.sv
// Self-checking bench for life_cell_serial: directed cases plus randomized generations
// compared against a neighbour-count/rule model. Honours LIFE_HIGHLIFE_EN like the RTL.

module tb_life_cell_serial;
    logic       clk;
    logic       rst;
    logic       load;
    logic       load_val;
    logic       start;
    logic       nb_valid;
    logic       nb_bit;
    logic       nb_ready;
    logic       state_q;
    logic [3:0] count_q;
    logic       busy;
    logic       done;

    int checks;
    int fails;
    int edges;
    logic model_state;

    life_cell_serial #(.INIT_STATE(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .nb_valid (nb_valid),
        .nb_bit   (nb_bit),
        .nb_ready (nb_ready),
        .state_q  (state_q),
        .count_q  (count_q),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic modelRule(input logic alive, input logic [7:0] bits);
        int n;
        n = $countones(bits);
`ifdef LIFE_HIGHLIFE_EN
        return (n == 3) || (alive && n == 2) || (!alive && n == 6);
`else
        return (n == 3) || (alive && n == 2);
`endif
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic applyLoad(input logic v, input logic with_start);
        load     = 1'b1;
        load_val = v;
        start    = with_start;
        nextCycle();
        load  = 1'b0;
        start = 1'b0;
        model_state = v;
        checkOutput("load_state", state_q, v);
        checkOutput("load_busy", busy, 1'b0);
        checkOutput("load_done", done, 1'b0);
    endtask

    // bits[i] is sent i-th; gapv[2i+:2] idle cycles precede bit i.
    task automatic applyStimulus(input logic [7:0] bits, input logic [15:0] gapv, input logic poke_busy);
        int run;
        int gtot;
        logic expect_state;
        run  = 0;
        gtot = 0;
        expect_state = modelRule(model_state, bits);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        edges = 0;
        checkOutput("accum_busy", busy, 1'b1);
        checkOutput("accum_ready", nb_ready, 1'b1);
        checkOutput("accum_clear", count_q, 0);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < int'(gapv[2*i +: 2]); g++) begin
                nb_valid = 1'b0;
                nb_bit   = 1'($urandom);
                if (poke_busy) begin
                    start    = 1'b1;
                    load     = 1'b1;
                    load_val = ~model_state;
                end
                nextCycle();
                start = 1'b0;
                load  = 1'b0;
                gtot++;
                checkOutput("gap_count", count_q, run);
                checkOutput("gap_ready", nb_ready, 1'b1);
            end
            nb_valid = 1'b1;
            nb_bit   = bits[i];
            nextCycle();
            nb_valid = 1'b0;
            run += int'(bits[i]);
            checkOutput("acc_count", count_q, run);
        end
        checkOutput("apply_busy", busy, 1'b1);
        checkOutput("apply_ready", nb_ready, 1'b0);
        checkOutput("apply_done", done, 1'b0);
        nextCycle();
        checkOutput("done_pulse", done, 1'b1);
        checkOutput("done_busy", busy, 1'b0);
        checkOutput("done_latency", edges, 9 + gtot);
        checkOutput("new_state", state_q, expect_state);
        checkOutput("final_count", count_q, $countones(bits));
        model_state = expect_state;
        nextCycle();
        checkOutput("done_drop", done, 1'b0);
        checkOutput("state_hold", state_q, model_state);
        checkOutput("count_hold", count_q, $countones(bits));
    endtask

    initial begin
        logic [7:0]  rbits;
        logic [15:0] rgaps;
        checks = 0;
        fails = 0;
        edges = 0;
        rst = 1'b1;
        load = 1'b0;
        load_val = 1'b0;
        start = 1'b0;
        nb_valid = 1'b0;
        nb_bit = 1'b0;
        model_state = 1'b0;
        @(negedge clk);
        checkOutput("rst_state", state_q, 1'b0);
        checkOutput("rst_count", count_q, 0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_ready", nb_ready, 1'b0);
        rst = 1'b0;
        nextCycle();

        applyStimulus(8'b0000_0111, 16'h0000, 1'b0);
        applyLoad(1'b0, 1'b0);
        applyLoad(1'b1, 1'b1);
        checkOutput("load_prio_idle", busy, 1'b0);
        applyStimulus(8'b0001_0010, 16'h0000, 1'b0);
        applyLoad(1'b1, 1'b0);
        applyStimulus(8'b0101_0101, 16'h0000, 1'b0);
        applyStimulus(8'b1010_0001, 16'h0444, 1'b1);
        applyStimulus(8'b1111_1111, 16'h0000, 1'b0);
        applyLoad(1'b0, 1'b0);
        applyStimulus(8'b0011_1111, 16'h0000, 1'b0);

        // Reset mid-accumulation after four accepted bits discards the generation.
        applyLoad(1'b1, 1'b0);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nb_valid = 1'b1;
            nb_bit   = 1'b1;
            nextCycle();
        end
        nb_valid = 1'b0;
        checkOutput("pre_rst_count", count_q, 4);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_state", state_q, 1'b0);
        checkOutput("mid_rst_count", count_q, 0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_ready", nb_ready, 1'b0);
        nextCycle();
        checkOutput("mid_rst_done", done, 1'b0);
        checkOutput("mid_rst_busy2", busy, 1'b0);
        rst = 1'b0;
        model_state = 1'b0;
        nextCycle();

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyLoad(1'($urandom), 1'($urandom));
            end
            rbits = 8'($urandom & $urandom);
            rgaps = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'h0000;
            applyStimulus(rbits, rgaps, 1'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/life_cell_serial.md
# life_cell_serial

Single Game-of-Life cell whose eight neighbour states arrive serially, one bit per cycle, over a valid/ready handshake. It accumulates the live-neighbour count with the team's `three_bit_adder`: the low 3 bits of the count feed the adder and the carry-out becomes count bit 3. It then applies the life rule and updates its stored state. It sits directly downstream of the adder and is the sequential consumer of its 3-bit sum plus carry.

## Interface
- `INIT_STATE`, default `1'b0`: value loaded into `state_q` on reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  in IDLE, write `load_val` into `state_q` on next edge.
- `load_val`  in  1  seed value for `state_q`.
- `start`  in  1  in IDLE, begin a generation.
- `nb_valid`  in  1  neighbour bit present.
- `nb_bit`  in  1  neighbour state (1 = alive).
- `nb_ready`  out  1  cell accepts a neighbour bit this cycle.
- `state_q`  out  1  current cell state (registered).
- `count_q`  out  4  live-neighbour count accumulated so far (0..8).
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse: `state_q` holds the new generation.

## Operation
- FSM states: IDLE, ACCUM, APPLY.
- **IDLE**
  - `nb_ready`=0.
  - `load` takes priority over `start`. When both are high, only the load happens and `start` is dropped.
  - `start` clears `count_q` and the 3-bit neighbour index, then moves to ACCUM.
- **ACCUM**
  - `nb_ready`=1.
  - On each edge with `nb_valid` high: `count_q` <= `count_q` + `nb_bit` (via `three_bit_adder`, carry into bit 3), and index increments.
  - The 8th accepted bit (index wraps 7 -> 0) moves the FSM to APPLY.
  - Cycles with `nb_valid`=0 change nothing.
- **APPLY**
  - `nb_ready`=0.
  - On the next edge: `state_q` <= rule(`state_q`, `count_q`), `done` is set for exactly one cycle, FSM returns to IDLE.
  - `count_q` holds its final value until the next `start`.
- Rule (B3/S23): next = (count==3) | (`state_q` & count==2).
- Count never exceeds 8. Count 8 = 4'b1000. Counts 4..8 always produce a dead cell (default build).
- `start` and `load` are ignored while `busy`.
- `rst` asserted at any time, including mid-ACCUM or in APPLY: immediately IDLE, `state_q`=`INIT_STATE`, `count_q`=0, index=0, `done`=0. The partial generation is discarded.

## Timing
- Reset values: `state_q`=`INIT_STATE`, `count_q`=0, `busy`=0, `done`=0, `nb_ready`=0.
- `start` sampled at edge E0 -> ACCUM from E0.
- With `nb_valid` held high, bits are accepted at E1..E8, APPLY runs after E8, and `state_q` updates with `done`=1 at E9.
- Minimum start-to-done latency is 9 edges. Each `nb_valid`=0 cycle in ACCUM adds one edge.
- `done` is high only for the cycle between E9 and E10. `busy` is low in that cycle.
- A new `start` is accepted in the same cycle `done` is high.
- `load` takes effect at the next edge. No `done` is produced for a load.
- Outputs are all registered except `nb_ready` and `busy`, which decode the FSM state directly.

## Configuration
- `LIFE_HIGHLIFE_EN`
  - Defined: HighLife rule B36/S23. Next = (count==3) | (~`state_q` & count==6) | (`state_q` & count==2).
  - Undefined: standard B3/S23 only. A dead cell with count 6 stays dead.
  - Latency and handshake are identical in both builds.

## Test plan
- Reset with `INIT_STATE`=0: `state_q`=0, `count_q`=0, `busy`=0, `done`=0, `nb_ready`=0. Also assert `rst` mid-ACCUM after 4 accepted bits -> same values on the next cycle.
- Dead cell, `start`, bits 1,1,1,0,0,0,0,0 with continuous valid -> `count_q`=3, `state_q`=1, `done` pulse exactly 9 edges after `start`.
- Load 1, then bits giving 2 neighbours -> `state_q` stays 1. Repeat with 4 neighbours -> `state_q`=0.
- Valid gaps: 3 idle cycles inserted in ACCUM with 3 live bits -> `done` at 12 edges, `state_q`=1. `start` pulsed while busy -> ignored, no extra `done`.
- All 8 neighbours live -> `count_q`=4'b1000, `state_q`=0.
- Dead cell with 6 neighbours -> `state_q`=0 without `LIFE_HIGHLIFE_EN`, 1 with it.
